ov7670_stream_tx: RTL and testbench
===================================

# ov7670_stream_tx

Synthesizable OV7670 camera emulator: drives pclk, vsync, href and an 8-bit data bus with RGB444 frames, byte-for-byte in the format `pixel_capture` receives from the real sensor. It sits in place of the camera pins. With it, the capture → BRAM → HDMI path can be brought up and regressed on hardware and in simulation with no sensor attached. Test pattern, frame geometry and blanking are configurable; `enable` starts and stops a continuous frame stream.

## Interface
- H_ACTIVE, 160, active pixels per line (two bytes each)
- V_ACTIVE, 120, active lines per frame
- H_BLANK, 16, pclk periods with href low at the end of every line
- VSYNC_LINES, 3, line periods with vsync high
- V_BP, 2, blank lines between vsync fall and first active line
- V_FP, 2, blank lines after the last active line
- clk  in  1  system clock; pclk is derived from it
- reset  in  1  synchronous, active-high
- enable  in  1  frames start only while high; a frame in progress always completes
- mode  in  2  pattern: 0 colour bars, 1 gradient, 2 solid, 3 checker
- solid_rgb  in  12  {R,G,B} colour used by mode 2
- pclk  out  1  pixel clock at clk/2
- vsync  out  1  frame sync, active high
- href  out  1  high while line bytes are valid
- d  out  8  data bus
- busy  out  1  high from the first vsync tick to the end of the last V_FP line
- frame_done  out  1  one-clk pulse when a frame ends
- frame_cnt  out  8  completed frames, wraps 255 → 0

## Operation
- pclk_r toggles every clk.
- tick = the clk edge where pclk_r goes 1 → 0.
- vsync, href, d and the FSM all update only on a tick, so they are stable for 2 clk around each pclk rise.
- Line period L = 2·H_ACTIVE + H_BLANK pclk. Every line, including blank and vsync lines, lasts L.
- FSM states: IDLE, VSYNC, VBP, ACTIVE, VFP.
  - IDLE → VSYNC on a tick with enable=1. mode and solid_rgb are latched at this transition.
  - VSYNC → VBP after VSYNC_LINES lines. VBP → ACTIVE after V_BP lines. ACTIVE → VFP after V_ACTIVE lines.
  - VFP ends after V_FP lines. On that tick: frame_done pulses, frame_cnt increments, and the next state is VSYNC if enable=1 (back-to-back frames, mode relatched) or IDLE otherwise.
- Signals by state:
  - vsync=1 only in VSYNC.
  - In ACTIVE, href=1 for the first 2·H_ACTIVE pclk of each line, then 0 for H_BLANK.
  - d=0 whenever href=0.
- Byte order per pixel (x,y) with colour {R,G,B}:
  - even byte = {4'h0, R}
  - odd byte = {G, B}
- Pattern colour, with x in 0..H_ACTIVE-1 and y in 0..V_ACTIVE-1:
  - Mode 0, colour bars: bar index = x / (H_ACTIVE/8). Bars in order: FFF, FF0, 0FF, 0F0, F0F, F00, 00F, 000.
  - Mode 1, gradient: R=x[3:0], G=y[3:0], B=frame_cnt[3:0].
  - Mode 2, solid: the latched solid_rgb.
  - Mode 3, checker: FFF if x[3]^y[3]^frame_cnt[0], else 000.
- enable low mid-frame has no effect until the frame ends. mode and solid_rgb changes mid-frame are ignored.

## Timing
- Reset values: pclk=0, vsync=0, href=0, d=0, busy=0, frame_done=0, frame_cnt=0, state IDLE, all counters 0. Reset mid-frame aborts immediately, with no frame_done.
- Latency from the enable-sampling tick to vsync=1 is 0: vsync rises on that same tick.
- vsync high time = VSYNC_LINES·L·2 clk (default 2016 clk).
- Frame period = (VSYNC_LINES+V_BP+V_ACTIVE+V_FP)·L·2 clk (default 127·336·2 = 85344 clk).
- frame_done is one clk wide and coincides with the tick that ends the last VFP line.
- Counter widths: column (pclk within line) $clog2(L); line $clog2(max(V_ACTIVE, VSYNC_LINES, V_BP, V_FP)+1). x = column>>1 is valid only while href=1.

## Structure
- Package ov7670_pkg holds:
  - state enum
  - pattern mode enum
  - 8-entry colour-bar constant array
  - function packing {R,G,B} plus byte parity into d
- One sub-module, ov7670_pattern_gen: purely combinational (x, y, frame_cnt, latched mode, latched solid) → 12-bit colour.
- The top holds the pclk divider, FSM and counters.

## Test plan
- Reset and idle: hold enable=0 for 1000 clk after reset → pclk toggling, vsync=href=d=busy=frame_done=0, frame_cnt=0.
- One default frame, mode 0: pulse enable for 2 clk → vsync high 2016 clk, exactly 120 href pulses of 320 bytes each, first bytes 0x0F,0xFF, byte pair at x=20 is 0x0F,0xF0, pair at x=159 is 0x00,0x00. Then one frame_done, frame_cnt=1, busy low, state IDLE.
- Back-to-back: hold enable=1 for 3 frames → next vsync rises on the frame_done tick, frame_cnt=3. In mode 1 the odd byte at (x=0,y=0) of frame 2 is 0x01.
- Mid-frame changes: switch mode 2 → 0 and solid_rgb at line 60 of a solid frame with solid_rgb=0xA5C → whole frame stays 0x0A,0x5C; the next frame is bars.
- Mid-frame stop: drop enable at line 30 → frame completes with all 120 lines, then IDLE; busy falls on the frame_done tick.
- Reset mid-frame: assert reset at line 50 → next clk all outputs at reset values, no frame_done, frame_cnt=0.
- Capture loopback: connect to pixel_capture → BRAM contents match the pattern_gen colours for all 19200 addresses.

Source files
------------

// File: rtl/ov7670_pkg.sv
// Shared types and helpers for the OV7670 camera emulator.
package ov7670_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_VSYNC  = 3'd1,
    ST_VBP    = 3'd2,
    ST_ACTIVE = 3'd3,
    ST_VFP    = 3'd4
  } state_e;

  typedef enum logic [1:0] {
    MODE_BARS  = 2'd0,
    MODE_GRAD  = 2'd1,
    MODE_SOLID = 2'd2,
    MODE_CHECK = 2'd3
  } mode_e;

  // Colour bars, left to right, as {R,G,B}
  localparam logic [11:0] BAR_RGB [8] = '{
    12'hFFF, 12'hFF0, 12'h0FF, 12'h0F0,
    12'hF0F, 12'hF00, 12'h00F, 12'h000
  };

  // RGB444 on the 8-bit bus: even byte carries R in the low nibble, odd byte carries {G,B}
  function automatic logic [7:0] pack_byte(input logic [11:0] rgb, input logic odd);
    return odd ? rgb[7:0] : {4'h0, rgb[11:8]};
  endfunction

endpackage

// File: rtl/ov7670_pattern_gen.sv
// Combinational test-pattern colour for one pixel position.
module ov7670_pattern_gen
  import ov7670_pkg::*;
#(
  parameter int H_ACTIVE = 160,
  parameter int XW       = 8
) (
  input  logic [XW-1:0] x_i,
  input  logic [3:0]    y_i,
  input  logic [3:0]    frame_cnt_i,
  input  mode_e         mode_i,
  input  logic [11:0]   solid_i,
  output logic [11:0]   rgb_o
);

  localparam int BAR_W = H_ACTIVE / 8;

  logic [2:0] bar_idx;

  // Select the colour for the latched pattern mode
  always_comb begin
    bar_idx = 3'(x_i / XW'(BAR_W));
    rgb_o   = 12'h000;
    case (mode_i)
      MODE_BARS:  rgb_o = BAR_RGB[bar_idx];
      MODE_GRAD:  rgb_o = {x_i[3:0], y_i, frame_cnt_i};
      MODE_SOLID: rgb_o = solid_i;
      MODE_CHECK: rgb_o = (x_i[3] ^ y_i[3] ^ frame_cnt_i[0]) ? 12'hFFF : 12'h000;
      default:    rgb_o = 12'h000;
    endcase
  end

endmodule

// File: rtl/ov7670_stream_tx.sv
// OV7670 sensor emulator: pclk divider, frame FSM and line/column counters.
// All sensor-side signals change only on the clk edge where pclk falls, so
// they are stable across each pclk rising edge seen by the capture logic.
module ov7670_stream_tx
  import ov7670_pkg::*;
#(
  parameter int H_ACTIVE    = 160,
  parameter int V_ACTIVE    = 120,
  parameter int H_BLANK     = 16,
  parameter int VSYNC_LINES = 3,
  parameter int V_BP        = 2,
  parameter int V_FP        = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  input  logic [1:0]  mode,
  input  logic [11:0] solid_rgb,
  output logic        pclk,
  output logic        vsync,
  output logic        href,
  output logic [7:0]  d,
  output logic        busy,
  output logic        frame_done,
  output logic [7:0]  frame_cnt
);

  localparam int L      = 2 * H_ACTIVE + H_BLANK;
  localparam int COL_W  = $clog2(L);
  localparam int M_A    = (V_ACTIVE > VSYNC_LINES) ? V_ACTIVE : VSYNC_LINES;
  localparam int M_B    = (V_BP > V_FP) ? V_BP : V_FP;
  localparam int M_ALL  = (M_A > M_B) ? M_A : M_B;
  localparam int LINE_W = $clog2(M_ALL + 1);
  localparam int XW     = ($clog2(H_ACTIVE) > 4) ? $clog2(H_ACTIVE) : 4;

  localparam logic [COL_W-1:0]  COL_LAST = COL_W'(L - 1);
  localparam logic [COL_W-1:0]  HREF_END = COL_W'(2 * H_ACTIVE);
  localparam logic [LINE_W-1:0] VS_LAST  = LINE_W'(VSYNC_LINES - 1);
  localparam logic [LINE_W-1:0] VBP_LAST = LINE_W'(V_BP - 1);
  localparam logic [LINE_W-1:0] ACT_LAST = LINE_W'(V_ACTIVE - 1);
  localparam logic [LINE_W-1:0] VFP_LAST = LINE_W'(V_FP - 1);

  logic              pclk_q;
  state_e            state_q, state_d;
  logic [COL_W-1:0]  col_q, col_d;
  logic [LINE_W-1:0] line_q, line_d;
  mode_e             mode_q, mode_d;
  logic [11:0]       solid_q, solid_d;
  logic [7:0]        frame_cnt_q, frame_cnt_d;
  logic              frame_done_q, frame_done_d;

  logic              tick;
  logic [LINE_W-1:0] line_last;
  logic              href_w;
  logic [XW-1:0]     x_w;
  logic [3:0]        y_w;
  logic [11:0]       rgb_w;

  // The edge on which pclk goes 1 -> 0 is the only edge that advances the stream
  assign tick = pclk_q;

  // State register, pclk divider and counters
  always_ff @(posedge clk) begin
    if (reset) begin
      pclk_q       <= 1'b0;
      state_q      <= ST_IDLE;
      col_q        <= '0;
      line_q       <= '0;
      mode_q       <= MODE_BARS;
      solid_q      <= 12'h000;
      frame_cnt_q  <= 8'h00;
      frame_done_q <= 1'b0;
    end else begin
      pclk_q       <= ~pclk_q;
      state_q      <= state_d;
      col_q        <= col_d;
      line_q       <= line_d;
      mode_q       <= mode_d;
      solid_q      <= solid_d;
      frame_cnt_q  <= frame_cnt_d;
      frame_done_q <= frame_done_d;
    end
  end

  // Next-state logic: column/line walk, state sequencing and frame bookkeeping
  always_comb begin
    state_d      = state_q;
    col_d        = col_q;
    line_d       = line_q;
    mode_d       = mode_q;
    solid_d      = solid_q;
    frame_cnt_d  = frame_cnt_q;
    frame_done_d = 1'b0;

    case (state_q)
      ST_VSYNC:  line_last = VS_LAST;
      ST_VBP:    line_last = VBP_LAST;
      ST_ACTIVE: line_last = ACT_LAST;
      ST_VFP:    line_last = VFP_LAST;
      default:   line_last = '0;
    endcase

    if (tick) begin
      if (state_q == ST_IDLE) begin
        if (enable) begin
          state_d = ST_VSYNC;
          col_d   = '0;
          line_d  = '0;
          mode_d  = mode_e'(mode);
          solid_d = solid_rgb;
        end
      end else if (col_q != COL_LAST) begin
        col_d = col_q + 1'b1;
      end else begin
        col_d = '0;
        if (line_q != line_last) begin
          line_d = line_q + 1'b1;
        end else begin
          line_d = '0;
          case (state_q)
            ST_VSYNC:  state_d = ST_VBP;
            ST_VBP:    state_d = ST_ACTIVE;
            ST_ACTIVE: state_d = ST_VFP;
            ST_VFP: begin
              frame_done_d = 1'b1;
              frame_cnt_d  = frame_cnt_q + 1'b1;
              if (enable) begin
                // Back-to-back frame: pattern settings are re-sampled here
                state_d = ST_VSYNC;
                mode_d  = mode_e'(mode);
                solid_d = solid_rgb;
              end else begin
                state_d = ST_IDLE;
              end
            end
            default:   state_d = ST_IDLE;
          endcase
        end
      end
    end
  end

  assign href_w = (state_q == ST_ACTIVE) && (col_q < HREF_END);
  assign x_w    = XW'(col_q >> 1);
  assign y_w    = 4'(line_q);

  ov7670_pattern_gen #(
    .H_ACTIVE (H_ACTIVE),
    .XW       (XW)
  ) u_pattern_gen (
    .x_i         (x_w),
    .y_i         (y_w),
    .frame_cnt_i (frame_cnt_q[3:0]),
    .mode_i      (mode_q),
    .solid_i     (solid_q),
    .rgb_o       (rgb_w)
  );

  assign pclk       = pclk_q;
  assign vsync      = (state_q == ST_VSYNC);
  assign href       = href_w;
  assign d          = href_w ? pack_byte(rgb_w, col_q[0]) : 8'h00;
  assign busy       = (state_q != ST_IDLE);
  assign frame_done = frame_done_q;
  assign frame_cnt  = frame_cnt_q;

endmodule

// File: tb/tb_ov7670_stream_tx.sv
// Scoreboard bench for ov7670_stream_tx using a reduced frame geometry.
module tb_ov7670_stream_tx;

  localparam int HA  = 16;
  localparam int VA  = 4;
  localparam int HB  = 4;
  localparam int VS  = 2;
  localparam int VBP = 1;
  localparam int VFP = 1;
  localparam int L   = 2 * HA + HB;
  localparam int FRAME_CLK   = (VS + VBP + VA + VFP) * L * 2;
  localparam int FRAME_BYTES = VA * 2 * HA;

  logic        clk = 1'b0;
  logic        reset, enable;
  logic [1:0]  mode;
  logic [11:0] solid_rgb;
  logic        pclk, vsync, href, busy, frame_done;
  logic [7:0]  d, frame_cnt;

  int checks = 0;
  int errors = 0;

  logic [7:0]  exp_bytes [$];
  logic [7:0]  exp_fcnt  [$];
  logic [7:0]  cap [FRAME_BYTES];
  logic [11:0] bars [8] = '{12'hFFF, 12'hFF0, 12'h0FF, 12'h0F0,
                            12'hF0F, 12'hF00, 12'h00F, 12'h000};
  int cap_idx = 0, line_bytes = 0, lines_seen = 0, vs_len = 0, frames_seen = 0;
  logic href_prev = 1'b0, vsync_prev = 1'b0;

  always #5 clk = ~clk;

  ov7670_stream_tx #(
    .H_ACTIVE    (HA),
    .V_ACTIVE    (VA),
    .H_BLANK     (HB),
    .VSYNC_LINES (VS),
    .V_BP        (VBP),
    .V_FP        (VFP)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .enable     (enable),
    .mode       (mode),
    .solid_rgb  (solid_rgb),
    .pclk       (pclk),
    .vsync      (vsync),
    .href       (href),
    .d          (d),
    .busy       (busy),
    .frame_done (frame_done),
    .frame_cnt  (frame_cnt)
  );

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s", name);
  endtask

  // Expected bytes for one whole frame, pattern computed from x, y and frame count
  task automatic push_frame(input int m, input logic [11:0] solid, input int fc);
    logic [11:0] c;
    for (int y = 0; y < VA; y++) begin
      for (int x = 0; x < HA; x++) begin
        case (m)
          0:       c = bars[x / (HA / 8)];
          1:       c = {4'(x), 4'(y), 4'(fc)};
          2:       c = solid;
          default: c = ((((x / 8) % 2) ^ ((y / 8) % 2) ^ (fc % 2)) != 0) ? 12'hFFF : 12'h000;
        endcase
        exp_bytes.push_back({4'h0, c[11:8]});
        exp_bytes.push_back(c[7:0]);
      end
    end
    exp_fcnt.push_back(8'(fc + 1));
  endtask

  task automatic wait_frame_done(input string name);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!frame_done && n < 2 * FRAME_CLK);
    if (!frame_done) fail({name, "_timeout"});
  endtask

  // Monitor: compares every href byte against the scoreboard and checks frame structure
  initial begin
    forever begin
      @(negedge clk);
      if (reset) begin
        href_prev  = 1'b0;
        vsync_prev = 1'b0;
        vs_len     = 0;
      end else begin
        if (frame_done) begin
          frames_seen++;
          if (exp_fcnt.size() == 0) fail("unexpected_frame_done");
          else check("frame_cnt", int'(frame_cnt), int'(exp_fcnt.pop_front()));
          check("lines_per_frame", lines_seen, VA);
          check("bytes_per_frame", cap_idx, FRAME_BYTES);
          $display("frame %0d done: frame_cnt=%0d lines=%0d bytes=%0d",
                   frames_seen, frame_cnt, lines_seen, cap_idx);
        end
        if (vsync) begin
          if (!vsync_prev) begin
            lines_seen = 0;
            cap_idx    = 0;
          end
          vs_len++;
        end else if (vsync_prev) begin
          check("vsync_width", vs_len, VS * L * 2);
          vs_len = 0;
        end
        vsync_prev = vsync;
        if (pclk) begin
          if (href) begin
            if (!href_prev) line_bytes = 0;
            if (exp_bytes.size() == 0) fail("unexpected_byte");
            else check("byte", int'(d), int'(exp_bytes.pop_front()));
            if (cap_idx < FRAME_BYTES) cap[cap_idx] = d;
            cap_idx++;
            line_bytes++;
          end else begin
            if (href_prev) begin
              check("bytes_per_line", line_bytes, 2 * HA);
              lines_seen++;
            end
            check("d_zero_outside_href", int'(d), 0);
          end
          href_prev = href;
        end
      end
    end
  end

  // Stimulus
  initial begin
    int toggles, bad, fd_before;
    logic pp;
    reset = 1'b1; enable = 1'b0; mode = 2'd0; solid_rgb = 12'h000;
    repeat (4) @(negedge clk);
    check("rst_pclk", int'(pclk), 0);
    check("rst_vsync", int'(vsync), 0);
    check("rst_href", int'(href), 0);
    check("rst_d", int'(d), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_frame_done", int'(frame_done), 0);
    check("rst_frame_cnt", int'(frame_cnt), 0);

    // Idle with enable low
    reset = 1'b0;
    toggles = 0; bad = 0; pp = pclk;
    repeat (200) begin
      @(negedge clk);
      if (pclk != pp) toggles++;
      pp = pclk;
      if ({vsync, href, d, busy, frame_done, frame_cnt} != '0) bad++;
    end
    check("idle_pclk_toggles", toggles, 200);
    check("idle_outputs_quiet", bad, 0);

    // One colour-bar frame from a 2-clk enable pulse
    mode = 2'd0;
    push_frame(0, 12'h000, 0);
    enable = 1'b1;
    @(negedge clk); @(negedge clk);
    enable = 1'b0;
    check("start_vsync", int'(vsync), 1);
    check("start_busy", int'(busy), 1);
    wait_frame_done("bars");
    check("bars_busy_low", int'(busy), 0);
    check("bars_idle_vsync", int'(vsync), 0);
    check("bars_x0_even", int'(cap[0]), 'h0F);
    check("bars_x0_odd", int'(cap[1]), 'hFF);
    check("bars_x4_odd", int'(cap[9]), 'hFF);
    check("bars_x4_even", int'(cap[8]), 'h00);
    check("bars_x10_even", int'(cap[20]), 'h0F);
    check("bars_x10_odd", int'(cap[21]), 'h00);
    check("bars_x15_odd", int'(cap[31]), 'h00);
    @(negedge clk);
    check("frame_done_width", int'(frame_done), 0);
    check("frame_cnt_after_1", int'(frame_cnt), 1);

    // Three back-to-back gradient frames
    mode = 2'd1;
    push_frame(1, 12'h000, 1);
    push_frame(1, 12'h000, 2);
    push_frame(1, 12'h000, 3);
    enable = 1'b1;
    wait_frame_done("grad1");
    check("b2b_vsync_on_done_1", int'(vsync), 1);
    check("grad_x0y0_odd", int'(cap[1]), 'h01);
    check("grad_x1y0_even", int'(cap[2]), 'h01);
    check("grad_x0y1_odd", int'(cap[2 * HA + 1]), 'h11);
    wait_frame_done("grad2");
    check("b2b_vsync_on_done_2", int'(vsync), 1);
    enable = 1'b0;
    wait_frame_done("grad3");
    check("grad3_x0y0_odd", int'(cap[1]), 'h03);
    check("grad3_busy_low", int'(busy), 0);
    check("grad3_frame_cnt", int'(frame_cnt), 4);

    // Solid frame with mode/colour changed mid-frame, then a bars frame stopped mid-frame
    mode = 2'd2; solid_rgb = 12'hA5C;
    push_frame(2, 12'hA5C, 4);
    push_frame(0, 12'h000, 5);
    enable = 1'b1;
    repeat ((VS + VBP + 2) * L * 2) @(negedge clk);
    mode = 2'd0; solid_rgb = 12'h123;
    wait_frame_done("solid");
    check("solid_b2b_vsync", int'(vsync), 1);
    check("solid_last_line_even", int'(cap[3 * 2 * HA]), 'h0A);
    check("solid_last_line_odd", int'(cap[3 * 2 * HA + 1]), 'h5C);
    repeat ((VS + VBP + 1) * L * 2) @(negedge clk);
    enable = 1'b0;
    wait_frame_done("stop");
    check("stop_busy_on_done", int'(busy), 0);
    check("stop_bars_x0_odd", int'(cap[1]), 'hFF);
    @(negedge clk);
    check("stop_idle_vsync", int'(vsync), 0);

    // Reset in the middle of a checker frame
    mode = 2'd3;
    push_frame(3, 12'h000, 6);
    enable = 1'b1;
    repeat ((VS + VBP + 2) * L * 2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    exp_bytes.delete();
    exp_fcnt.delete();
    fd_before = frames_seen;
    enable = 1'b0;
    check("midrst_pclk", int'(pclk), 0);
    check("midrst_href", int'(href), 0);
    check("midrst_d", int'(d), 0);
    check("midrst_busy", int'(busy), 0);
    check("midrst_frame_done", int'(frame_done), 0);
    check("midrst_frame_cnt", int'(frame_cnt), 0);
    @(negedge clk);
    reset = 1'b0;
    repeat (FRAME_CLK) @(negedge clk);
    check("midrst_no_frame_done", frames_seen, fd_before);
    check("midrst_cnt_stays_0", int'(frame_cnt), 0);
    check("midrst_idle_busy", int'(busy), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
